// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: controller FSM states, EX/MEM memory-control bit positions
// and the hard-wired zero register specifier.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } ctrl_state_t;

    localparam int M_READ_BIT  = 1;
    localparam int M_WRITE_BIT = 0;
    localparam int REG_ZERO    = 0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of the instruction in IF/ID.
// Purely combinational, zero latency; no flow control of its own.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_idex_memread,
    input  logic [REG_W-1:0] i_idex_rt,
    input  logic [REG_W-1:0] i_ifid_rs,
    input  logic [REG_W-1:0] i_ifid_rt,
    output logic             o_lu_stall
);

    logic w_rt_nonzero;
    logic w_src_match;

    // $zero is never a real dependency, so a load into it never stalls
    assign w_rt_nonzero = (i_idex_rt != REG_W'(REG_ZERO));
    assign w_src_match  = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
    assign o_lu_stall   = i_idex_memread && w_rt_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait FSM, hazard priority mux, stall counter.
// Controls are combinational in the same cycle; a memory stall outranks branch squash, which outranks load-use.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16,
    parameter int REG_W   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             branch_taken,
    input  logic [1:0]       exmem_m,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                 WCNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0]  WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_cnt_nxt;
    logic              r_mem_error;
    logic [CNT_W-1:0]  r_stall_count;

    logic w_mem_op;
    logic w_mem_req;
    logic w_mem_stall;
    logic w_err_set;
    logic w_lu_stall;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .i_idex_memread (idex_memread),
        .i_idex_rt      (idex_rt),
        .i_ifid_rs      (ifid_rs),
        .i_ifid_rt      (ifid_rt),
        .o_lu_stall     (w_lu_stall)
    );

    assign w_mem_op = exmem_m[M_READ_BIT] | exmem_m[M_WRITE_BIT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
        end
    end

    // exmem_m is only looked at in RUN: while waiting EX/MEM is held and cannot change
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_err_set   = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_stall = 1'b0;
        case (r_state)
            RUN: begin
                w_mem_req = w_mem_op;
                if (w_mem_op && !mem_ready) begin
                    w_mem_stall = 1'b1;
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = WCNT_W'(1);
                end
            end
            WAIT: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_mem_stall = 1'b1;
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt = ERROR;
                        w_err_set   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_wait_cnt + WCNT_W'(1);
                    end
                end
            end
            ERROR: begin
                w_mem_stall = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        if (!reset) begin
            mem_req = w_mem_req;
            if (w_mem_stall) begin
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end else if (branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_lu_stall) begin
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_error   <= 1'b0;
            r_stall_count <= '0;
        end else begin
            if (w_err_set) begin
                r_mem_error <= 1'b1;
            end
            if (!pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign mem_error   = r_mem_error;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (long and short timeout) share stimulus and are
// compared against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_ctrl;

    localparam int A_TO = 64;
    localparam int A_CW = 16;
    localparam int B_TO = 4;
    localparam int B_CW = 3;
    localparam int A_MAX = (1 << A_CW) - 1;
    localparam int B_MAX = (1 << B_CW) - 1;

    // Output vector order: {mem_req, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble, mem_error}
    localparam logic [7:0] V_IDLE   = 8'b0000_0000;
    localparam logic [7:0] V_RUN    = 8'b0110_0000;
    localparam logic [7:0] V_LU     = 8'b0000_1000;
    localparam logic [7:0] V_BRANCH = 8'b0111_1000;
    localparam logic [7:0] V_MSTALL = 8'b1000_0110;
    localparam logic [7:0] V_MDONE  = 8'b1110_0000;
    localparam logic [7:0] V_ERROR  = 8'b0000_0111;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rt = '0;
    logic [4:0] ifid_rs = '0;
    logic [4:0] ifid_rt = '0;
    logic       branch_taken = 1'b0;
    logic [1:0] exmem_m = '0;
    logic       mem_ready = 1'b0;

    logic            mem_req_a, pc_write_a, ifid_write_a, ifid_flush_a;
    logic            idex_bubble_a, exmem_hold_a, memwb_bubble_a, mem_error_a;
    logic [A_CW-1:0] stall_count_a;
    logic            mem_req_b, pc_write_b, ifid_write_b, ifid_flush_b;
    logic            idex_bubble_b, exmem_hold_b, memwb_bubble_b, mem_error_b;
    logic [B_CW-1:0] stall_count_b;
    logic [7:0]      obs_a, obs_b;

    int total = 0;
    int bad   = 0;

    int a_waited, b_waited, a_cnt, b_cnt;
    bit a_err, b_err;

    pipeline_ctrl #(.TIMEOUT(A_TO), .CNT_W(A_CW), .REG_W(5)) dut_a (
        .clock(clock), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .branch_taken(branch_taken), .exmem_m(exmem_m),
        .mem_ready(mem_ready), .mem_req(mem_req_a), .pc_write(pc_write_a), .ifid_write(ifid_write_a),
        .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a), .exmem_hold(exmem_hold_a),
        .memwb_bubble(memwb_bubble_a), .mem_error(mem_error_a), .stall_count(stall_count_a)
    );

    pipeline_ctrl #(.TIMEOUT(B_TO), .CNT_W(B_CW), .REG_W(5)) dut_b (
        .clock(clock), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .branch_taken(branch_taken), .exmem_m(exmem_m),
        .mem_ready(mem_ready), .mem_req(mem_req_b), .pc_write(pc_write_b), .ifid_write(ifid_write_b),
        .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b), .exmem_hold(exmem_hold_b),
        .memwb_bubble(memwb_bubble_b), .mem_error(mem_error_b), .stall_count(stall_count_b)
    );

    assign obs_a = {mem_req_a, pc_write_a, ifid_write_a, ifid_flush_a,
                    idex_bubble_a, exmem_hold_a, memwb_bubble_a, mem_error_a};
    assign obs_b = {mem_req_b, pc_write_b, ifid_write_b, ifid_flush_b,
                    idex_bubble_b, exmem_hold_b, memwb_bubble_b, mem_error_b};

    always #5 clock = ~clock;

    // waited = stall cycles already spent on the outstanding access (0 = none outstanding)
    function automatic logic [7:0] expect_ctrl(input int waited, input bit err);
        bit mem_op, req, mstall, lu;
        if (reset) return V_IDLE;
        mem_op = (exmem_m != 2'b00);
        if (err) begin
            req = 1'b0; mstall = 1'b1;
        end else if (waited > 0) begin
            req = 1'b1; mstall = !mem_ready;
        end else begin
            req = mem_op; mstall = mem_op && !mem_ready;
        end
        lu = idex_memread && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
        if (mstall)            return {req, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, err};
        else if (branch_taken) return {req, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, err};
        else if (lu)           return {req, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, err};
        else                   return {req, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, err};
    endfunction

    task automatic clear_model();
        a_waited = 0; b_waited = 0; a_cnt = 0; b_cnt = 0; a_err = 0; b_err = 0;
    endtask

    task automatic drive(input bit mr, input logic [4:0] lrt, input logic [4:0] rs,
                         input logic [4:0] rt, input bit br, input logic [1:0] em, input bit rdy);
        idex_memread = mr; idex_rt = lrt; ifid_rs = rs; ifid_rt = rt;
        branch_taken = br; exmem_m = em; mem_ready = rdy;
        #2;
    endtask

    task automatic advance();
        logic [7:0] ea, eb;
        ea = expect_ctrl(a_waited, a_err);
        eb = expect_ctrl(b_waited, b_err);
        @(posedge clock);
        if (reset) begin
            clear_model();
        end else begin
            if (!ea[6] && a_cnt < A_MAX) a_cnt++;
            if (!a_err) begin
                if (ea[2]) begin
                    a_waited++;
                    if (a_waited == A_TO) a_err = 1;
                end else a_waited = 0;
            end
            if (!eb[6] && b_cnt < B_MAX) b_cnt++;
            if (!b_err) begin
                if (eb[2]) begin
                    b_waited++;
                    if (b_waited == B_TO) b_err = 1;
                end else b_waited = 0;
            end
        end
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        clear_model();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_model();
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        total++; if (obs_a !== V_IDLE) begin bad++; $display("FAIL rst_outputs got=%b want=%b", obs_a, V_IDLE); end
        total++; if (stall_count_a !== '0) begin bad++; $display("FAIL rst_count got=%0d want=0", stall_count_a); end
        reset = 1'b0;
        #1;
        total++; if (obs_a !== V_RUN) begin bad++; $display("FAIL rst_release got=%b want=%b", obs_a, V_RUN); end
        advance();
        drive(0, 0, 0, 0, 0, 2'b10, 0);
        for (int i = 0; i < 5; i++) advance();
        drive(0, 0, 0, 0, 0, 2'b10, 0);
        total++; if (obs_a !== V_MSTALL) begin bad++; $display("FAIL wait5_outputs got=%b want=%b", obs_a, V_MSTALL); end
        total++; if (stall_count_a !== A_CW'(5)) begin bad++; $display("FAIL wait5_count got=%0d want=5", stall_count_a); end
        reset = 1'b1;
        clear_model();
        #1;
        total++; if (obs_a !== V_IDLE) begin bad++; $display("FAIL midwait_rst got=%b want=%b", obs_a, V_IDLE); end
        total++; if (stall_count_a !== '0) begin bad++; $display("FAIL midwait_rst_count got=%0d want=0", stall_count_a); end
        total++; if (obs_b !== V_IDLE) begin bad++; $display("FAIL midwait_rst_b got=%b want=%b", obs_b, V_IDLE); end
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        total++; if (obs_a !== V_RUN) begin bad++; $display("FAIL post_rst_run got=%b want=%b", obs_a, V_RUN); end
        advance();
    endtask

    task automatic test_load_use();
        drive(1, 5'd8, 5'd8, 5'd3, 0, 2'b00, 0);
        total++; if (obs_a !== V_LU) begin bad++; $display("FAIL lu_rs got=%b want=%b", obs_a, V_LU); end
        advance();
        drive(0, 5'd8, 5'd8, 5'd3, 0, 2'b00, 0);
        total++; if (obs_a !== V_RUN) begin bad++; $display("FAIL lu_release got=%b want=%b", obs_a, V_RUN); end
        advance();
        drive(1, 5'd9, 5'd2, 5'd9, 0, 2'b00, 0);
        total++; if (obs_a !== V_LU) begin bad++; $display("FAIL lu_rt got=%b want=%b", obs_a, V_LU); end
        advance();
        drive(1, 5'd0, 5'd0, 5'd0, 0, 2'b00, 0);
        total++; if (obs_a !== V_RUN) begin bad++; $display("FAIL lu_zero got=%b want=%b", obs_a, V_RUN); end
        total++; if (stall_count_a !== a_cnt[A_CW-1:0]) begin bad++; $display("FAIL lu_count got=%0d want=%0d", stall_count_a, a_cnt); end
        advance();
    endtask

    task automatic test_branch();
        drive(1, 5'd8, 5'd8, 5'd0, 1, 2'b00, 0);
        total++; if (obs_a !== V_BRANCH) begin bad++; $display("FAIL branch_lu got=%b want=%b", obs_a, V_BRANCH); end
        advance();
    endtask

    task automatic test_mem_wait();
        pulse_reset();
        drive(0, 0, 0, 0, 0, 2'b10, 0);
        total++; if (obs_a !== V_MSTALL) begin bad++; $display("FAIL mw_c1 got=%b want=%b", obs_a, V_MSTALL); end
        advance();
        drive(0, 0, 0, 0, 1, 2'b10, 0);
        total++; if (obs_a !== V_MSTALL) begin bad++; $display("FAIL mw_c2 got=%b want=%b", obs_a, V_MSTALL); end
        advance();
        drive(0, 0, 0, 0, 0, 2'b10, 1);
        total++; if (obs_a !== V_MDONE) begin bad++; $display("FAIL mw_c3 got=%b want=%b", obs_a, V_MDONE); end
        advance();
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        total++; if (obs_a !== V_RUN) begin bad++; $display("FAIL mw_c4 got=%b want=%b", obs_a, V_RUN); end
        total++; if (stall_count_a !== A_CW'(2)) begin bad++; $display("FAIL mw_count got=%0d want=2", stall_count_a); end
        advance();
    endtask

    task automatic test_zero_wait();
        pulse_reset();
        drive(0, 0, 0, 0, 0, 2'b01, 1);
        total++; if (obs_a !== V_MDONE) begin bad++; $display("FAIL zw_access got=%b want=%b", obs_a, V_MDONE); end
        advance();
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        total++; if (obs_a !== V_RUN) begin bad++; $display("FAIL zw_after got=%b want=%b", obs_a, V_RUN); end
        total++; if (stall_count_a !== '0) begin bad++; $display("FAIL zw_count got=%0d want=0", stall_count_a); end
        advance();
    endtask

    task automatic test_timeout();
        pulse_reset();
        for (int i = 0; i < B_TO; i++) begin
            drive(0, 0, 0, 0, 0, 2'b10, 0);
            total++; if (obs_b !== V_MSTALL) begin bad++; $display("FAIL to_stall%0d got=%b want=%b", i, obs_b, V_MSTALL); end
            advance();
        end
        drive(0, 0, 0, 0, 0, 2'b10, 1);
        total++; if (obs_b !== V_ERROR) begin bad++; $display("FAIL to_error got=%b want=%b", obs_b, V_ERROR); end
        for (int i = 0; i < 6; i++) advance();
        drive(1, 5'd4, 5'd4, 5'd0, 1, 2'b00, 1);
        total++; if (obs_b !== V_ERROR) begin bad++; $display("FAIL to_sticky got=%b want=%b", obs_b, V_ERROR); end
        total++; if (stall_count_b !== 3'd7) begin bad++; $display("FAIL to_saturate got=%0d want=7", stall_count_b); end
        total++; if (stall_count_a !== a_cnt[A_CW-1:0]) begin bad++; $display("FAIL to_count_a got=%0d want=%0d", stall_count_a, a_cnt); end
        advance();
    endtask

    task automatic test_random();
        logic [7:0] ea, eb;
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            if (reset) clear_model();
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0));
            ea = expect_ctrl(a_waited, a_err);
            eb = expect_ctrl(b_waited, b_err);
            total++; if (obs_a !== ea) begin bad++; $display("FAIL rnd_a n=%0d got=%b want=%b", n, obs_a, ea); end
            total++; if (obs_b !== eb) begin bad++; $display("FAIL rnd_b n=%0d got=%b want=%b", n, obs_b, eb); end
            total++; if (stall_count_a !== a_cnt[A_CW-1:0]) begin bad++; $display("FAIL rnd_cnt_a n=%0d got=%0d want=%0d", n, stall_count_a, a_cnt); end
            total++; if (stall_count_b !== b_cnt[B_CW-1:0]) begin bad++; $display("FAIL rnd_cnt_b n=%0d got=%0d want=%0d", n, stall_count_b, b_cnt); end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_zero_wait();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
